// File: rtl/channel_readout_serializer.sv
// rtl/channel_readout_serializer.sv - framed byte serialiser draining per-channel capture buffers
// Header, masked channel words (MSB-first or low byte only) per sample, footer; all outputs registered.
module channel_readout_serializer #(
  parameter int         NUM_CH     = 4,
  parameter int         WORD_BYTES = 2,
  parameter logic [7:0] FRAME_MARK = 8'h80,
  parameter logic [7:0] HDR_CODE   = 8'h02,
  parameter logic [7:0] FTR_CODE   = 8'h01
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_CH-1:0]              i_ch_ready,
  input  logic [NUM_CH*WORD_BYTES*8-1:0] i_ch_data,
  output logic [NUM_CH-1:0]              o_ch_rd,
  input  logic [NUM_CH-1:0]              i_ch_mask,
  input  logic                           i_single_byte,
  input  logic                           i_rd_en,
  output logic [7:0]                     o_out_byte,
  output logic                           o_out_valid,
  output logic                           o_frame_active,
  output logic [15:0]                    o_sample_count
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BI_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BI_W-1:0] LAST_BI = BI_W'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_POP,
    S_CHECK,
    S_FOOTER
  } state_t;

  state_t              r_state;
  logic                r_hdr_idx;
  logic [CH_W-1:0]     r_ch;
  logic [BI_W-1:0]     r_byte_idx;
  logic [NUM_CH-1:0]   r_lmask;
  logic                r_single;
  logic [7:0]          r_out_byte;
  logic                r_out_valid;
  logic [NUM_CH-1:0]   r_ch_rd;
  logic                r_frame_active;
  logic [15:0]         r_sample_count;

  state_t              w_state_nxt;
  logic                w_hdr_nxt;
  logic [CH_W-1:0]     w_ch_nxt;
  logic [BI_W-1:0]     w_bidx_nxt;
  logic [NUM_CH-1:0]   w_lmask_nxt;
  logic                w_single_nxt;
  logic [7:0]          w_byte_nxt;
  logic                w_valid_nxt;
  logic [NUM_CH-1:0]   w_rd_nxt;
  logic                w_active_nxt;
  logic [15:0]         w_count_nxt;
  logic                w_load;
  logic                w_accept;
  logic                w_last_byte;
  logic [CH_W-1:0]     w_first_ch;
  logic [CH_W-1:0]     w_next_ch;
  logic                w_has_next;
  logic [BI_W-1:0]     w_bsel;
  logic [7:0]          w_data_byte;
  logic [WORD_BYTES-1:0][7:0] w_words [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_words
    assign w_words[k] = i_ch_data[k*WORD_BYTES*8 +: WORD_BYTES*8];
  end

  // Lowest enabled channel, and the next enabled channel above the current one.
  always_comb begin
    w_first_ch = '0;
    w_next_ch  = '0;
    w_has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_lmask[i]) begin
        w_first_ch = CH_W'(i);
        if (CH_W'(i) > r_ch) begin
          w_next_ch  = CH_W'(i);
          w_has_next = 1'b1;
        end
      end
    end
  end

  assign w_accept    = r_out_valid & i_rd_en;
  assign w_last_byte = r_single | (r_byte_idx == LAST_BI);

  always_comb begin
    w_state_nxt  = r_state;
    w_hdr_nxt    = r_hdr_idx;
    w_ch_nxt     = r_ch;
    w_bidx_nxt   = r_byte_idx;
    w_lmask_nxt  = r_lmask;
    w_single_nxt = r_single;
    w_byte_nxt   = r_out_byte;
    w_valid_nxt  = r_out_valid;
    w_rd_nxt     = '0;
    w_active_nxt = r_frame_active;
    w_count_nxt  = r_sample_count;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        if ((i_ch_ready & i_ch_mask) != '0) begin
          w_lmask_nxt  = i_ch_mask;
          w_single_nxt = i_single_byte;
          w_count_nxt  = '0;
          w_state_nxt  = S_HEADER;
          w_hdr_nxt    = 1'b0;
          w_byte_nxt   = FRAME_MARK;
          w_valid_nxt  = 1'b1;
          w_active_nxt = 1'b1;
        end
      end
      S_HEADER: begin
        if (w_accept) begin
          if (!r_hdr_idx) begin
            w_hdr_nxt  = 1'b1;
            w_byte_nxt = HDR_CODE;
          end else begin
            w_state_nxt = S_DATA;
            w_ch_nxt    = w_first_ch;
            w_bidx_nxt  = '0;
            w_load      = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_accept) begin
          if (!w_last_byte) begin
            w_bidx_nxt = r_byte_idx + BI_W'(1);
            w_load     = 1'b1;
          end else begin
            w_rd_nxt[r_ch] = 1'b1;
            if (w_has_next) begin
              w_ch_nxt   = w_next_ch;
              w_bidx_nxt = '0;
              w_load     = 1'b1;
            end else begin
              w_state_nxt = S_POP;
              w_valid_nxt = 1'b0;
            end
          end
        end
      end
      S_POP: begin
        w_state_nxt = S_CHECK;
        if (r_sample_count != 16'hFFFF) begin
          w_count_nxt = r_sample_count + 16'd1;
        end
      end
      S_CHECK: begin
        if ((i_ch_ready & r_lmask) != '0) begin
          w_state_nxt = S_DATA;
          w_ch_nxt    = w_first_ch;
          w_bidx_nxt  = '0;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_FOOTER;
          w_hdr_nxt   = 1'b0;
          w_byte_nxt  = FRAME_MARK;
          w_valid_nxt = 1'b1;
        end
      end
      S_FOOTER: begin
        if (w_accept) begin
          if (!r_hdr_idx) begin
            w_hdr_nxt  = 1'b1;
            w_byte_nxt = FTR_CODE;
          end else begin
            w_state_nxt  = S_IDLE;
            w_valid_nxt  = 1'b0;
            w_active_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Byte lane of the word about to be presented; index 0 is the least significant byte.
  always_comb begin
    w_bsel      = r_single ? '0 : (LAST_BI - w_bidx_nxt);
    w_data_byte = w_words[w_ch_nxt][w_bsel];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_hdr_idx      <= 1'b0;
      r_ch           <= '0;
      r_byte_idx     <= '0;
      r_lmask        <= '0;
      r_single       <= 1'b0;
      r_out_byte     <= 8'h00;
      r_out_valid    <= 1'b0;
      r_ch_rd        <= '0;
      r_frame_active <= 1'b0;
      r_sample_count <= 16'h0000;
    end else begin
      r_state        <= w_state_nxt;
      r_hdr_idx      <= w_hdr_nxt;
      r_ch           <= w_ch_nxt;
      r_byte_idx     <= w_bidx_nxt;
      r_lmask        <= w_lmask_nxt;
      r_single       <= w_single_nxt;
      r_out_byte     <= w_load ? w_data_byte : w_byte_nxt;
      r_out_valid    <= w_load | w_valid_nxt;
      r_ch_rd        <= w_rd_nxt;
      r_frame_active <= w_active_nxt;
      r_sample_count <= w_count_nxt;
    end
  end

  assign o_ch_rd        = r_ch_rd;
  assign o_out_byte     = r_out_byte;
  assign o_out_valid    = r_out_valid;
  assign o_frame_active = r_frame_active;
  assign o_sample_count = r_sample_count;

endmodule

// File: tb/tb_channel_readout_serializer.sv
// tb/tb_channel_readout_serializer.sv - directed bench for channel_readout_serializer
module tb_channel_readout_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_ready;
  logic [63:0] ch_data;
  logic [3:0]  ch_rd;
  logic [3:0]  ch_mask;
  logic        single_byte;
  logic        rd_en;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        frame_active;
  logic [15:0] sample_count;

  always #5 clk = ~clk;

  channel_readout_serializer #(
    .NUM_CH(4), .WORD_BYTES(2), .FRAME_MARK(8'h80), .HDR_CODE(8'h02), .FTR_CODE(8'h01)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_ch_ready(ch_ready), .i_ch_data(ch_data), .o_ch_rd(ch_rd),
    .i_ch_mask(ch_mask), .i_single_byte(single_byte), .i_rd_en(rd_en), .o_out_byte(out_byte),
    .o_out_valid(out_valid), .o_frame_active(frame_active), .o_sample_count(sample_count)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] got_q[$];
  int         rd_ch_q[$];
  int         rd_at_q[$];
  logic [7:0] exp_b[$];
  int         exp_ch[$];
  int         exp_at[$];
  int         popped[4];
  int         budget[4];
  logic [3:0] prev_rd;
  int         n_multi, n_repeat, n_gap;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic update_ready();
    for (int k = 0; k < 4; k++) ch_ready[k] = (popped[k] < budget[k]);
  endtask

  // Called once per cycle at the falling edge, after rd_en for the coming edge is settled.
  task automatic record();
    if ($countones(ch_rd) > 1) n_multi++;
    if ((ch_rd & prev_rd) != 4'b0) n_repeat++;
    for (int k = 0; k < 4; k++) begin
      if (ch_rd[k]) begin
        rd_ch_q.push_back(k);
        rd_at_q.push_back(got_q.size());
        popped[k]++;
      end
    end
    prev_rd = ch_rd;
    if (frame_active && !out_valid) n_gap++;
    if (out_valid && rd_en) got_q.push_back(out_byte);
    update_ready();
  endtask

  task automatic run_frame(input logic [3:0] mask, input logic single, input int nsamp,
                           input logic [7:0] stall_byte, input int stall_len);
    logic seen, done, stalled;
    int   stalling;
    got_q.delete(); rd_ch_q.delete(); rd_at_q.delete();
    n_multi = 0; n_repeat = 0; n_gap = 0;
    ch_mask = mask; single_byte = single; rd_en = 1'b1;
    for (int k = 0; k < 4; k++) budget[k] = popped[k] + nsamp;
    update_ready();
    seen = 1'b0; done = 1'b0; stalled = 1'b0; stalling = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (stall_len > 0 && !stalled && out_valid && out_byte == stall_byte) begin
        stalled  = 1'b1;
        stalling = stall_len;
      end
      if (stalling > 0) begin
        rd_en = 1'b0;
        check_eq("stall_hold", {23'd0, out_valid, out_byte}, {23'd0, 1'b1, stall_byte});
        stalling--;
      end else begin
        rd_en = 1'b1;
      end
      record();
      if (frame_active) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    check_eq("frame_done", {31'd0, done}, 32'd1);
  endtask

  task automatic check_frame(input string name, input int exp_count, input int exp_gap);
    check_eq({name, "_len"}, got_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size(); i++)
      check_eq($sformatf("%s_byte%0d", name, i), (i < got_q.size()) ? {24'd0, got_q[i]} : 32'h1ff,
               {24'd0, exp_b[i]});
    check_eq({name, "_rd_len"}, rd_ch_q.size(), exp_ch.size());
    for (int i = 0; i < exp_ch.size(); i++) begin
      check_eq($sformatf("%s_rd_ch%0d", name, i), (i < rd_ch_q.size()) ? rd_ch_q[i] : -1, exp_ch[i]);
      check_eq($sformatf("%s_rd_at%0d", name, i), (i < rd_at_q.size()) ? rd_at_q[i] : -1, exp_at[i]);
    end
    check_eq({name, "_count"}, {16'd0, sample_count}, exp_count);
    check_eq({name, "_gap"}, n_gap, exp_gap);
    check_eq({name, "_rd_multi"}, n_multi, 0);
    check_eq({name, "_rd_repeat"}, n_repeat, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, "_byte"}, {24'd0, out_byte}, 32'h00);
    check_eq({name, "_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({name, "_rd"}, {28'd0, ch_rd}, 32'd0);
    check_eq({name, "_active"}, {31'd0, frame_active}, 32'd0);
    check_eq({name, "_count"}, {16'd0, sample_count}, 32'd0);
  endtask

  initial begin
    logic seen9a;
    ch_data = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
    rst = 1'b1; ch_mask = 4'b0; single_byte = 1'b0; rd_en = 1'b0; prev_rd = 4'b0;
    for (int k = 0; k < 4; k++) begin popped[k] = 0; budget[k] = 0; end
    update_ready();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    exp_b  = '{8'h80, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h80, 8'h01};
    exp_ch = '{0, 1, 2, 3};
    exp_at = '{4, 6, 8, 10};
    run_frame(4'b1111, 1'b0, 1, 8'h00, 0);
    check_frame("full", 1, 2);

    exp_b  = '{8'h80, 8'h02, 8'h12, 8'h34, 8'h9A, 8'hBC, 8'h80, 8'h01};
    exp_ch = '{0, 2};
    exp_at = '{4, 6};
    run_frame(4'b0101, 1'b0, 1, 8'h00, 0);
    check_frame("mask0101", 1, 2);

    exp_b  = '{8'h80, 8'h02, 8'h34, 8'h78, 8'hBC, 8'hF0, 8'h80, 8'h01};
    exp_ch = '{0, 1, 2, 3};
    exp_at = '{3, 4, 5, 6};
    run_frame(4'b1111, 1'b1, 1, 8'h00, 0);
    check_frame("single", 1, 2);

    exp_b  = '{8'h80, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h80, 8'h01};
    exp_ch = '{0, 1, 2, 3};
    exp_at = '{4, 6, 8, 10};
    run_frame(4'b1111, 1'b0, 1, 8'h56, 5);
    check_frame("stall", 1, 2);

    exp_b = '{8'h80, 8'h02};
    exp_ch.delete(); exp_at.delete();
    for (int s = 0; s < 3; s++) begin
      exp_b.push_back(8'h12); exp_b.push_back(8'h34); exp_b.push_back(8'h56); exp_b.push_back(8'h78);
      exp_b.push_back(8'h9A); exp_b.push_back(8'hBC); exp_b.push_back(8'hDE); exp_b.push_back(8'hF0);
      for (int k = 0; k < 4; k++) begin
        exp_ch.push_back(k);
        exp_at.push_back(4 + 8 * s + 2 * k);
      end
    end
    exp_b.push_back(8'h80); exp_b.push_back(8'h01);
    run_frame(4'b1111, 1'b0, 3, 8'h00, 0);
    check_frame("three", 3, 6);

    ch_mask = 4'b1111; single_byte = 1'b0; rd_en = 1'b1;
    for (int k = 0; k < 4; k++) budget[k] = popped[k] + 1000;
    update_ready();
    seen9a = 1'b0;
    for (int cyc = 0; cyc < 50 && !seen9a; cyc++) begin
      @(negedge clk);
      if (out_valid && out_byte == 8'h9A) seen9a = 1'b1;
    end
    check_eq("abort_seen_9a", {31'd0, seen9a}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    ch_mask = 4'b0000;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      check_eq($sformatf("mask0_idle%0d", cyc), {26'd0, out_valid, frame_active, ch_rd}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
